// File: rtl/cache_pkg.sv
// Shared types and helpers for the data-cache miss/refill controller.
package cache_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned MAX_ADDR_WIDTH     = 64;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        FILL,
        WR_REQ
    } state_t;

    // Clears the byte offset; callers zero-extend into and truncate out of MAX_ADDR_WIDTH.
    function automatic logic [MAX_ADDR_WIDTH-1:0] word_align(input logic [MAX_ADDR_WIDTH-1:0] addr);
        return {addr[MAX_ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_miss_handler.sv
// Read-miss refill and write-through store controller sitting behind the direct-mapped data cache.
module cache_miss_handler
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    input  logic                  cache_hit_i,
    output logic                  stall_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rdata_valid_o,
    output logic                  fill_we_o,
    output logic [ADDR_WIDTH-1:0] fill_addr_o,
    output logic [DATA_WIDTH-1:0] fill_data_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [CNT_WIDTH-1:0]  read_hits_o,
    output logic [CNT_WIDTH-1:0]  read_misses_o
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  hit_q;
    logic [ADDR_WIDTH-1:0] cpu_addr_aligned;

    logic hit_inc, miss_inc, latch_rd, latch_wr, capture;

    assign cpu_addr_aligned = ADDR_WIDTH'(word_align(MAX_ADDR_WIDTH'(cpu_addr_i)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request copies: everything after IDLE runs off these, not the live cpu_* inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            hit_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            if (latch_rd || latch_wr) begin
                addr_q <= cpu_addr_aligned;
            end
            if (latch_wr) begin
                wdata_q <= cpu_wdata_i;
                hit_q   <= cache_hit_i;
            end
            if (capture) begin
                data_q <= mem_rdata_i;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        stall_o       = 1'b0;
        rdata_o       = '0;
        rdata_valid_o = 1'b0;
        fill_we_o     = 1'b0;
        fill_addr_o   = '0;
        fill_data_o   = '0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        latch_rd      = 1'b0;
        latch_wr      = 1'b0;
        capture       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    if (cpu_we_i) begin
                        stall_o  = 1'b1;
                        latch_wr = 1'b1;
                        state_d  = WR_REQ;
                    end else if (cache_hit_i) begin
                        hit_inc = 1'b1;
                    end else begin
                        stall_o  = 1'b1;
                        latch_rd = 1'b1;
                        miss_inc = 1'b1;
                        state_d  = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                stall_o    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = addr_q;
                if (mem_gnt_i) begin
                    capture = mem_rvalid_i;
                    state_d = mem_rvalid_i ? FILL : RD_WAIT;
                end
            end
            RD_WAIT: begin
                stall_o = 1'b1;
                if (mem_rvalid_i) begin
                    capture = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                fill_we_o     = 1'b1;
                fill_addr_o   = addr_q;
                fill_data_o   = data_q;
                rdata_o       = data_q;
                rdata_valid_o = 1'b1;
                state_d       = IDLE;
            end
            WR_REQ: begin
                stall_o     = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
                // Posted write: release the pipeline on grant; update the cache only if the line was present.
                if (mem_gnt_i) begin
                    stall_o = 1'b0;
                    state_d = IDLE;
                    if (hit_q) begin
                        fill_we_o   = 1'b1;
                        fill_addr_o = addr_q;
                        fill_data_o = wdata_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit_inc),
        .count (read_hits_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (miss_inc),
        .count (read_misses_o)
    );

endmodule

// File: tb/tb_cache_miss_handler.sv
// Scoreboard bench for cache_miss_handler: directed cases then random traffic against a memory model.
module tb_cache_miss_handler;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk, rst_n;
    logic          cpu_req_i, cpu_we_i, cache_hit_i;
    logic [AW-1:0] cpu_addr_i;
    logic [DW-1:0] cpu_wdata_i;
    logic          stall_o, rdata_valid_o, fill_we_o, mem_req_o, mem_we_o;
    logic [DW-1:0] rdata_o, fill_data_o, mem_wdata_o, mem_rdata_i;
    logic [AW-1:0] fill_addr_o, mem_addr_o;
    logic          mem_gnt_i, mem_rvalid_i;
    logic [CW-1:0] read_hits_o, read_misses_o;

    cache_miss_handler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cache_hit_i(cache_hit_i),
        .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .fill_we_o(fill_we_o), .fill_addr_o(fill_addr_o), .fill_data_o(fill_data_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .read_hits_o(read_hits_o), .read_misses_o(read_misses_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } mem_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          is_read;
    } fill_exp_t;

    mem_exp_t  exp_mem[$];
    fill_exp_t exp_fill[$];

    int total = 0;
    int bad   = 0;
    int m_hits = 0;
    int m_misses = 0;

    logic [DW-1:0] mem_model [logic [AW-1:0]];

    bit fixed_mode = 1'b1;
    int fix_g = 0, fix_lat = 0;
    int last_g = 0, last_lat = 0;
    bit in_req = 1'b0, rd_pending = 1'b0;
    int gnt_wait = 0, rd_wait = 0;
    logic [DW-1:0] rd_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (!mem_model.exists(a)) mem_model[a] = {a[15:0], ~a[15:0]} ^ 32'h5A3C_0000;
        return mem_model[a];
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Memory responder: grants after a chosen delay, returns read data a chosen latency after grant.
    initial begin
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
            if (rd_pending) begin
                if (rd_wait == 0) begin
                    mem_rvalid_i = 1'b1; mem_rdata_i = rd_data; rd_pending = 1'b0;
                end else begin
                    rd_wait--;
                end
            end else if (mem_req_o && rst_n) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    gnt_wait = fixed_mode ? fix_g : int'($urandom_range(0, 3));
                    last_g = gnt_wait;
                end
                if (gnt_wait == 0) begin
                    mem_gnt_i = 1'b1; in_req = 1'b0;
                    if (!mem_we_o) begin
                        rd_data = mem_read(mem_addr_o);
                        last_lat = fixed_mode ? fix_lat : int'($urandom_range(0, 3));
                        if (last_lat == 0) begin
                            mem_rvalid_i = 1'b1; mem_rdata_i = rd_data;
                        end else begin
                            rd_pending = 1'b1; rd_wait = last_lat - 1;
                        end
                    end
                end else begin
                    gnt_wait--;
                end
            end else if (!fixed_mode && $urandom_range(0, 7) == 0) begin
                mem_rvalid_i = 1'b1; mem_rdata_i = $urandom;
            end
        end
    end

    // Monitor: pops expected memory accesses and cache writes as the DUT presents them.
    initial begin
        mem_exp_t  me;
        fill_exp_t fe;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_req_o && mem_gnt_i) begin
                    if (exp_mem.size() == 0) begin
                        check("mem_unexpected", 64'd1, 64'd0);
                    end else begin
                        me = exp_mem.pop_front();
                        check("mem_we", 64'(mem_we_o), 64'(me.we));
                        check("mem_addr", 64'(mem_addr_o), 64'(me.addr));
                        check("mem_wdata", 64'(mem_wdata_o), 64'(me.data));
                    end
                end
                if (!mem_req_o) begin
                    check("mem_idle_addr", 64'(mem_addr_o), 64'd0);
                    check("mem_idle_wdata", 64'(mem_wdata_o), 64'd0);
                end
                if (fill_we_o) begin
                    if (exp_fill.size() == 0) begin
                        check("fill_unexpected", 64'd1, 64'd0);
                    end else begin
                        fe = exp_fill.pop_front();
                        check("fill_addr", 64'(fill_addr_o), 64'(fe.addr));
                        check("fill_data", 64'(fill_data_o), 64'(fe.data));
                        check("rdata_valid", 64'(rdata_valid_o), 64'(fe.is_read));
                        if (fe.is_read) check("rdata", 64'(rdata_o), 64'(fe.data));
                    end
                end else if (rdata_valid_o) begin
                    check("rdata_valid_unexpected", 64'd1, 64'd0);
                end
            end
        end
    end

    // One CPU access; entered and left just after a rising edge.
    task automatic access(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input bit hit);
        logic [AW-1:0] al;
        mem_exp_t  me;
        fill_exp_t fe;
        int  stalls;
        bit  done;
        al = addr & 32'hFFFF_FFFC;
        if (we) begin
            me.we = 1'b1; me.addr = al; me.data = wdata; exp_mem.push_back(me);
            mem_model[al] = wdata;
            if (hit) begin
                fe.addr = al; fe.data = wdata; fe.is_read = 1'b0; exp_fill.push_back(fe);
            end
        end else if (!hit) begin
            me.we = 1'b0; me.addr = al; me.data = '0; exp_mem.push_back(me);
            fe.addr = al; fe.data = mem_read(al); fe.is_read = 1'b1; exp_fill.push_back(fe);
            m_misses = sat(m_misses + 1);
        end else begin
            m_hits = sat(m_hits + 1);
        end
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wdata; cache_hit_i = hit;
        @(negedge clk);
        check("idle_stall", 64'(stall_o), 64'(we || !hit));
        if (!we && hit) check("hit_no_mem_req", 64'(mem_req_o), 64'd0);
        @(posedge clk); #1;
        cpu_req_i = (we || !hit) ? 1'($urandom) : 1'b0;
        cpu_we_i = 1'($urandom); cpu_addr_i = $urandom; cpu_wdata_i = $urandom; cache_hit_i = 1'($urandom);
        if (we || !hit) begin
            stalls = 1; done = 1'b0;
            for (int i = 0; i < 100 && !done; i++) begin
                @(negedge clk);
                if (stall_o) stalls++;
                else done = 1'b1;
            end
            if (!done) begin
                check("stall_timeout", 64'd1, 64'd0);
            end else if (we) begin
                check("wr_gnt_fill_we", 64'(fill_we_o), 64'(hit));
                check("wr_stall_cycles", 64'(stalls), 64'(1 + last_g));
            end else begin
                check("rd_fill_on_release", 64'({fill_we_o, rdata_valid_o}), 64'd3);
                check("rd_stall_cycles", 64'(stalls), 64'(2 + last_g + last_lat));
            end
            @(posedge clk); #1;
            cpu_req_i = 1'b0;
        end
        check("read_hits", 64'(read_hits_o), 64'(m_hits));
        check("read_misses", 64'(read_misses_o), 64'(m_misses));
    endtask

    task automatic reset_mid_miss();
        mem_exp_t me;
        bit found;
        fixed_mode = 1'b1; fix_g = 0; fix_lat = 8;
        me.we = 1'b0; me.addr = 32'h300; me.data = '0; exp_mem.push_back(me);
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h300; cache_hit_i = 1'b0;
        @(posedge clk); #1;
        cpu_req_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (stall_o && !mem_req_o) found = 1'b1;
        end
        check("reached_rd_wait", 64'(found), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_stall", 64'(stall_o), 64'd0);
        check("rst_misses", 64'(read_misses_o), 64'd0);
        rst_n = 1'b1;
        m_hits = 0; m_misses = 0;
        exp_fill.delete();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_rst_stall", 64'(stall_o), 64'd0);
            check("post_rst_fill_we", 64'(fill_we_o), 64'd0);
            check("post_rst_rdata_valid", 64'(rdata_valid_o), 64'd0);
        end
        check("late_rvalid_delivered", 64'(rd_pending), 64'd0);
        check("post_rst_hits", 64'(read_hits_o), 64'd0);
        check("post_rst_misses", 64'(read_misses_o), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0; cache_hit_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", 64'(stall_o), 64'd0);
        check("reset_mem_req", 64'(mem_req_o), 64'd0);
        check("reset_fill_we", 64'(fill_we_o), 64'd0);
        check("reset_rdata_valid", 64'(rdata_valid_o), 64'd0);
        check("reset_hits", 64'(read_hits_o), 64'd0);
        check("reset_misses", 64'(read_misses_o), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        access(1'b0, 32'h100, '0, 1'b1);

        fix_g = 2; fix_lat = 3;
        mem_model[32'h200] = 32'hDEADBEEF;
        access(1'b0, 32'h203, '0, 1'b0);

        fix_g = 0; fix_lat = 0;
        access(1'b0, 32'h40C, '0, 1'b0);

        fix_g = 1;
        access(1'b1, 32'h40, 32'h11, 1'b1);
        access(1'b1, 32'h80, 32'h22, 1'b0);

        reset_mid_miss();

        for (int i = 0; i < 5; i++) access(1'b0, $urandom, '0, 1'b1);

        fixed_mode = 1'b0;
        for (int i = 0; i < 300; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                @(posedge clk); #1;
            end
            access(1'($urandom), 32'h1000 + 32'($urandom_range(0, 255)), $urandom, 1'($urandom));
        end

        fixed_mode = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("mem_queue_drained", 64'(exp_mem.size()), 64'd0);
        check("fill_queue_drained", 64'(exp_fill.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
